// File: rtl/sensor_round_scheduler.sv
// sensor_round_scheduler: fires three ultrasonic sensors in turn with a timeout and a guard gap between them, then combines the valid readings
// Ports: clock, reset (async active-low); iniciar starts a round; medir/pronto_sensor/medida0..2 talk to the sensor interfaces;
// distancia/valida/falha hold the last round's result; fim_medida pulses at round end; ocupado, db_estado, db_sensor for status/debug.
// Build option: define SENSOR_MEDIAN_EN for median / pair-average combining; otherwise the lowest-index valid reading is used.
module sensor_round_scheduler #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int GUARD_CYCLES   = 3000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  output logic [2:0]  medir,
  input  logic [2:0]  pronto_sensor,
  input  logic [11:0] medida0,
  input  logic [11:0] medida1,
  input  logic [11:0] medida2,
  output logic [11:0] distancia,
  output logic        valida,
  output logic [2:0]  falha,
  output logic        fim_medida,
  output logic        ocupado,
  output logic [3:0]  db_estado,
  output logic [3:0]  db_sensor
);
  localparam int MAXC = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  typedef enum logic [3:0] {IDLE = 4'd0, DISPARA = 4'd1, ESPERA = 4'd2, GUARDA = 4'd3, CALCULA = 4'd4, FIM = 4'd5} state_t;
  state_t          r_state;
  logic [1:0]      r_idx;
  logic [2:0]      r_ok;
  logic [11:0]     r_m0, r_m1, r_m2;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_medir;
  logic [11:0]     r_dist;
  logic            r_valida;
  logic [2:0]      r_falha;
  logic            r_fim;
  logic            w_pronto;
  logic [11:0]     w_sel;
  logic [11:0]     w_first;
  logic [11:0]     w_comb;
  assign w_pronto = |(pronto_sensor & (3'b001 << r_idx));
  assign w_sel    = (r_idx == 2'd0) ? medida0 : (r_idx == 2'd1) ? medida1 : medida2;
  assign w_first  = r_ok[0] ? r_m0 : r_ok[1] ? r_m1 : r_m2;
`ifdef SENSOR_MEDIAN_EN
  logic [11:0] w_lo, w_hi, w_hc, w_med3, w_pa, w_pb;
  logic [12:0] w_sum;
  logic        w_two;
  assign w_lo   = (r_m0 < r_m1) ? r_m0 : r_m1;
  assign w_hi   = (r_m0 < r_m1) ? r_m1 : r_m0;
  assign w_hc   = (w_hi < r_m2) ? w_hi : r_m2;
  assign w_med3 = (w_lo > w_hc) ? w_lo : w_hc;
  // the pair is whichever two flags are set; the odd one out selects the mux legs
  assign w_pa   = r_ok[0] ? r_m0 : r_m1;
  assign w_pb   = r_ok[2] ? r_m2 : r_m1;
  assign w_sum  = {1'b0, w_pa} + {1'b0, w_pb};
  assign w_two  = (r_ok == 3'b011) || (r_ok == 3'b101) || (r_ok == 3'b110);
  assign w_comb = (&r_ok) ? w_med3 : w_two ? w_sum[12:1] : w_first;
`else
  assign w_comb = w_first;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_ok     <= 3'b000;
      r_m0     <= '0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_timer  <= '0;
      r_medir  <= 3'b000;
      r_dist   <= '0;
      r_valida <= 1'b0;
      r_falha  <= 3'b000;
      r_fim    <= 1'b0;
    end else begin
      r_medir <= 3'b000;
      r_fim   <= 1'b0;
      case (r_state)
        IDLE: if (iniciar) begin
          r_idx   <= 2'd0;
          r_ok    <= 3'b000;
          r_m0    <= '0;
          r_m1    <= '0;
          r_m2    <= '0;
          r_medir <= 3'b001;
          r_state <= DISPARA;
        end
        DISPARA: begin
          r_timer <= '0;
          r_state <= ESPERA;
        end
        ESPERA: begin
          r_timer <= r_timer + 1'b1;
          if (w_pronto || r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timer <= '0;
            r_state <= GUARDA;
          end
          // a zero distance counts as a failed reading: no latch, no ok flag
          if (w_pronto && w_sel != 12'd0) begin
            r_ok[r_idx] <= 1'b1;
            if (r_idx == 2'd0) r_m0 <= w_sel;
            if (r_idx == 2'd1) r_m1 <= w_sel;
            if (r_idx == 2'd2) r_m2 <= w_sel;
          end
        end
        GUARDA: begin
          r_timer <= r_timer + 1'b1;
          if (r_timer == TW'(GUARD_CYCLES - 1)) begin
            r_timer <= '0;
            if (r_idx == 2'd2) r_state <= CALCULA;
            else begin
              r_idx   <= r_idx + 2'd1;
              r_medir <= 3'b010 << r_idx;
              r_state <= DISPARA;
            end
          end
        end
        CALCULA: begin
          if (|r_ok) r_dist <= w_comb;
          r_valida <= |r_ok;
          r_falha  <= ~r_ok;
          r_fim    <= 1'b1;
          r_state  <= FIM;
        end
        FIM:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign medir      = r_medir;
  assign distancia  = r_dist;
  assign valida     = r_valida;
  assign falha      = r_falha;
  assign fim_medida = r_fim;
  assign ocupado    = (r_state != IDLE);
  assign db_estado  = r_state;
  assign db_sensor  = {2'b00, r_idx};
endmodule

// File: tb/tb_sensor_round_scheduler.sv
// tb_sensor_round_scheduler: table-driven rounds plus hand-written reset abort for sensor_round_scheduler
module tb_sensor_round_scheduler;
  localparam int T = 100;
  localparam int G = 20;
`ifdef SENSOR_MEDIAN_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iniciar = 1'b0;
  logic [2:0]  pronto_sensor = 3'b000;
  logic [11:0] medida0 = '0, medida1 = '0, medida2 = '0;
  logic [2:0]  medir;
  logic [11:0] distancia;
  logic        valida;
  logic [2:0]  falha;
  logic        fim_medida, ocupado;
  logic [3:0]  db_estado, db_sensor;
  int checks = 0;
  int errors = 0;

  sensor_round_scheduler #(.TIMEOUT_CYCLES(T), .GUARD_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .medir(medir),
    .pronto_sensor(pronto_sensor), .medida0(medida0), .medida1(medida1), .medida2(medida2),
    .distancia(distancia), .valida(valida), .falha(falha), .fim_medida(fim_medida),
    .ocupado(ocupado), .db_estado(db_estado), .db_sensor(db_sensor));

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0][11:0] v;
    logic [2:0]       silent;
    int               dly;
    bit               stray;
    bit               ini_guard;
    logic [11:0]      exp_dist;
    logic             exp_val;
    logic [2:0]       exp_falha;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic pulse_sensor(input int i, input logic [11:0] val);
    if (i == 0) medida0 = val;
    if (i == 1) medida1 = val;
    if (i == 2) medida2 = val;
    pronto_sensor = 3'b001 << i;
    step();
    pronto_sensor = 3'b000;
  endtask

  task automatic run_round(input vec_t c);
    int n;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (medir == 3'b000 && n < 300) begin step(); n++; end
      chk("medir_onehot", medir, 32'(3'b001 << i));
      chk("db_sensor", db_sensor, i);
      chk("ocupado", ocupado, 1);
      step();
      chk("medir_width", medir, 0);
      if (c.silent[i]) begin
        n = 0;
        while (db_estado == 4'd2 && n < 300) begin step(); n++; end
        chk("timeout_len", n, T);
      end else begin
        if (i == 0 && c.stray) begin
          medida2 = 12'd999;
          pronto_sensor = 3'b100;
          step();
          pronto_sensor = 3'b000;
          chk("stray_ignored", db_estado, 2);
        end
        repeat (c.dly) step();
        pulse_sensor(i, c.v[i]);
      end
      chk("guarda_entry", db_estado, 3);
      n = 0;
      while (db_estado == 4'd3 && n < 300) begin
        iniciar = (i == 1 && c.ini_guard && n == 3);
        step();
        n++;
      end
      iniciar = 1'b0;
      chk("guard_len", n, G);
    end
    chk("calcula", db_estado, 4);
    step();
    chk("fim_pulse", fim_medida, 1);
    chk("fim_state", db_estado, 5);
    chk("distancia", distancia, c.exp_dist);
    chk("valida", valida, c.exp_val);
    chk("falha", falha, c.exp_falha);
    step();
    chk("fim_width", fim_medida, 0);
    chk("idle_after", db_estado, 0);
    n = 0;
    repeat (40) begin step(); if (medir != 3'b000 || db_estado != 4'd0 || fim_medida) n++; end
    chk("no_extra_round", n, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{v:{12'd110, 12'd120, 12'd100}, silent:3'b000, dly:3, stray:0, ini_guard:0,
                exp_dist:(MED ? 12'd110 : 12'd100), exp_val:1, exp_falha:3'b000};
    vecs[1] = '{v:{12'd0, 12'd0, 12'd0}, silent:3'b111, dly:0, stray:0, ini_guard:0,
                exp_dist:(MED ? 12'd110 : 12'd100), exp_val:0, exp_falha:3'b111};
    vecs[2] = '{v:{12'd110, 12'd0, 12'd100}, silent:3'b010, dly:5, stray:0, ini_guard:0,
                exp_dist:(MED ? 12'd105 : 12'd100), exp_val:1, exp_falha:3'b010};
    vecs[3] = '{v:{12'd210, 12'd220, 12'd200}, silent:3'b000, dly:4, stray:1, ini_guard:1,
                exp_dist:(MED ? 12'd210 : 12'd200), exp_val:1, exp_falha:3'b000};
    vecs[4] = '{v:{12'd200, 12'd300, 12'd0}, silent:3'b000, dly:2, stray:0, ini_guard:0,
                exp_dist:(MED ? 12'd250 : 12'd300), exp_val:1, exp_falha:3'b001};
    vecs[5] = '{v:{12'd0, 12'd77, 12'd0}, silent:3'b101, dly:0, stray:0, ini_guard:0,
                exp_dist:12'd77, exp_val:1, exp_falha:3'b101};
    vecs[6] = '{v:{12'd0, 12'd4095, 12'd4000}, silent:3'b100, dly:1, stray:0, ini_guard:0,
                exp_dist:(MED ? 12'd4047 : 12'd4000), exp_val:1, exp_falha:3'b100};
    vecs[7] = '{v:{12'd60, 12'd50, 12'd50}, silent:3'b000, dly:7, stray:0, ini_guard:0,
                exp_dist:12'd50, exp_val:1, exp_falha:3'b000};
    #1;
    chk("rst_medir", medir, 0);
    chk("rst_dist", distancia, 0);
    chk("rst_valida", valida, 0);
    chk("rst_falha", falha, 0);
    chk("rst_fim", fim_medida, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_sensor", db_sensor, 0);
    step();
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < 8; k++) run_round(vecs[k]);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    n = 0;
    while (!(db_sensor == 4'd1 && db_estado == 4'd2) && n < 400) begin step(); n++; end
    chk("reach_espera1", db_estado, 2);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("abort_medir", medir, 0);
    chk("abort_dist", distancia, 0);
    chk("abort_valida", valida, 0);
    chk("abort_falha", falha, 0);
    chk("abort_fim", fim_medida, 0);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_estado", db_estado, 0);
    chk("abort_sensor", db_sensor, 0);
    step();
    step();
    reset = 1'b1;
    n = 0;
    repeat (50) begin step(); if (medir != 3'b000 || db_estado != 4'd0) n++; end
    chk("no_medir_after_reset", n, 0);
    run_round(vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
